// File: rtl/pipe_stage_reg.sv
// Elastic multi-slot pipeline register with valid/ready handshake,
// bubble collapse, global stall and flush (start_i low acts as flush).
//
// Ports:
//   clk_i, rst_i (async, active low)
//   start_i, flush_i, stall_i     : run enable, flush, freeze
//   in_valid_i / in_ready_o       : upstream handshake
//   in_ctrl_i, in_data_i          : upstream payload
//   out_valid_o / out_ready_i     : downstream handshake
//   out_ctrl_o, out_data_o        : payload of the output slot
//   count_o                       : number of valid slots
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 9,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DEPTH-1:0]  v;
  logic [CTRL_W-1:0] ctrl [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];

  logic [DEPTH-1:0]  move;
  logic [DEPTH-1:0]  leave;
  logic [CTRL_W-1:0] src_ctrl [DEPTH];
  logic [DATA_W-1:0] src_data [DEPTH];
  logic              kill;
  logic              rdy;
  logic              acc;
  logic              xfer;

  assign kill = flush_i | ~start_i;

  // Moves are resolved from the output side back to the input so an
  // item can step into a slot that is being vacated in the same cycle.
  always_comb begin
    move  = '0;
    leave = '0;
    rdy   = 1'b0;
    if (!kill && !stall_i) begin
      leave[DEPTH-1] = v[DEPTH-1] & out_ready_i;
      for (int k = DEPTH - 1; k > 0; k--) begin
        move[k]    = v[k-1] & (~v[k] | leave[k]);
        leave[k-1] = move[k];
      end
      rdy = ~v[0] | leave[0];
    end
    move[0] = in_valid_i & rdy;
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      src_ctrl[k] = in_ctrl_i;
      src_data[k] = in_data_i;
    end
    for (int k = 1; k < DEPTH; k++) begin
      src_ctrl[k] = ctrl[k-1];
      src_data[k] = data[k-1];
    end
  end

  assign acc  = move[0];
  assign xfer = leave[DEPTH-1];

  // Emptied slots zero their control field; data is left untouched.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl[k] <= '0;
        data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (kill) begin
          v[k]    <= 1'b0;
          ctrl[k] <= '0;
        end else if (move[k]) begin
          v[k]    <= 1'b1;
          ctrl[k] <= src_ctrl[k];
          data[k] <= src_data[k];
        end else if (leave[k]) begin
          v[k]    <= 1'b0;
          ctrl[k] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_o <= '0;
    end else if (kill) begin
      count_o <= '0;
    end else begin
      unique case ({acc, xfer})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

  assign in_ready_o  = rdy;
  assign out_valid_o = v[DEPTH-1];
  assign out_ctrl_o  = ctrl[DEPTH-1];
  assign out_data_o  = data[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (DEPTH 1..3)
// share stimulus; each scenario checks the instance it targets.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b1;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        rdy1, rdy2, rdy3;
  logic        ov1, ov2, ov3;
  logic [8:0]  oc1, oc2, oc3;
  logic [63:0] od1, od2, od3;
  logic [2:0]  cnt1, cnt2, cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEPTH(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .stall_i(stall), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(ov1),
    .out_ready_i(out_ready), .out_ctrl_o(oc1), .out_data_o(od1),
    .count_o(cnt1));

  pipe_stage_reg #(.DEPTH(2)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .stall_i(stall), .in_valid_i(in_valid), .in_ready_o(rdy2),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(ov2),
    .out_ready_i(out_ready), .out_ctrl_o(oc2), .out_data_o(od2),
    .count_o(cnt2));

  pipe_stage_reg #(.DEPTH(3)) u3 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .stall_i(stall), .in_valid_i(in_valid), .in_ready_o(rdy3),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(ov3),
    .out_ready_i(out_ready), .out_ctrl_o(oc3), .out_data_o(od3),
    .count_o(cnt3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    stall     = 1'b0;
    start     = 1'b1;
    out_ready = 1'b0;
    rst       = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({ov1, ov2, ov3} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_valid: got %b want 000", {ov1, ov2, ov3});
    end
    n_cmp++;
    if ({cnt1, cnt2, cnt3} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_count: got %h want 0", {cnt1, cnt2, cnt3});
    end
    n_cmp++;
    if ({oc1, oc2, oc3, od1, od2, od3} !== '0) begin
      n_bad++;
      $display("FAIL reset_payload: got nonzero want 0");
    end
    do_reset();
  endtask

  task automatic test_depth1();
    do_reset();
    in_valid = 1'b1;
    in_ctrl  = 9'h1A5;
    in_data  = 64'hDEAD;
    n_cmp++;
    if (rdy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL d1_ready: got %b want 1", rdy1);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({ov1, oc1, od1, cnt1} !== {1'b1, 9'h1A5, 64'hDEAD, 3'd1}) begin
      n_bad++;
      $display("FAIL d1_out: got v=%b c=%h d=%h n=%0d want 1 1a5 dead 1",
               ov1, oc1, od1, cnt1);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      in_valid = (c <= 10);
      in_data  = 64'(c);
      in_ctrl  = 9'(c);
      if (c <= 10) begin
        n_cmp++;
        if (rdy3 !== 1'b1) begin
          n_bad++;
          $display("FAIL stream_ready c=%0d: got %b want 1", c, rdy3);
        end
      end
      tick();
      n_cmp++;
      if (c >= 3 && c <= 12) begin
        if (ov3 !== 1'b1 || od3 !== 64'(c - 2) || oc3 !== 9'(c - 2)) begin
          n_bad++;
          $display("FAIL stream_out c=%0d: got v=%b d=%0d want 1 %0d",
                   c, ov3, od3, c - 2);
        end
      end else if (ov3 !== 1'b0 || oc3 !== 9'h0) begin
        n_bad++;
        $display("FAIL stream_idle c=%0d: got v=%b c=%h want 0 0",
                 c, ov3, oc3);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(100 + i);
      in_ctrl  = 9'(i);
      n_cmp++;
      if (rdy3 !== 1'b1) begin
        n_bad++;
        $display("FAIL full_fill%0d: got ready %b want 1", i, rdy3);
      end
      tick();
    end
    in_data = 64'd104;
    in_ctrl = 9'd4;
    n_cmp++;
    if (cnt3 !== 3'd3 || rdy3 !== 1'b0) begin
      n_bad++;
      $display("FAIL full_block: got n=%0d r=%b want 3 0", cnt3, rdy3);
    end
    tick();
    n_cmp++;
    if (cnt3 !== 3'd3 || od3 !== 64'd101 || rdy3 !== 1'b0) begin
      n_bad++;
      $display("FAIL full_hold: got n=%0d d=%0d r=%b want 3 101 0",
               cnt3, od3, rdy3);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (rdy3 !== 1'b1) begin
      n_bad++;
      $display("FAIL full_pass_ready: got %b want 1", rdy3);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (cnt3 !== 3'd3 || od3 !== 64'd102 || oc3 !== 9'd2) begin
      n_bad++;
      $display("FAIL full_pass: got n=%0d d=%0d c=%h want 3 102 002",
               cnt3, od3, oc3);
    end
    tick();
    n_cmp++;
    if (cnt3 !== 3'd3 || od3 !== 64'd102) begin
      n_bad++;
      $display("FAIL full_item4: got n=%0d d=%0d want 3 102", cnt3, od3);
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1'b1;
    in_ctrl  = 9'h0AA;
    in_data  = 64'hA;
    tick();
    in_ctrl  = 9'h0BB;
    in_data  = 64'hB;
    tick();
    stall     = 1'b1;
    out_ready = 1'b1;
    in_data   = 64'hC;
    #1;
    n_cmp++;
    if (rdy2 !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_ready: got %b want 0", rdy2);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({ov2, oc2, od2, cnt2, rdy2} !==
          {1'b1, 9'h0AA, 64'hA, 3'd2, 1'b0}) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got v=%b c=%h d=%h n=%0d r=%b",
                 i, ov2, oc2, od2, cnt2, rdy2);
      end
    end
    stall     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_flush(input bit use_start);
    do_reset();
    in_valid = 1'b1;
    in_ctrl  = 9'h1FF;
    in_data  = 64'h11;
    tick();
    in_data  = 64'h22;
    tick();
    in_data = 64'h33;
    if (use_start) start = 1'b0;
    else flush = 1'b1;
    #1;
    n_cmp++;
    if (rdy2 !== 1'b0) begin
      n_bad++;
      $display("FAIL flush%0d_ready: got %b want 0", use_start, rdy2);
    end
    tick();
    n_cmp++;
    if ({cnt2, ov2, oc2, od2} !== {3'd0, 1'b0, 9'h0, 64'h11}) begin
      n_bad++;
      $display("FAIL flush%0d_out: got n=%0d v=%b c=%h d=%h want 0 0 0 11",
               use_start, cnt2, ov2, oc2, od2);
    end
    flush    = 1'b0;
    start    = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (cnt2 !== 3'd0 || ov2 !== 1'b0) begin
      n_bad++;
      $display("FAIL flush%0d_drop: got n=%0d v=%b want 0 0",
               use_start, cnt2, ov2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1;
    in_ctrl  = 9'h055;
    in_data  = 64'h5;
    tick();
    in_data  = 64'h6;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (ov2 !== 1'b1 || cnt3 !== 3'd2) begin
      n_bad++;
      $display("FAIL arst_pre: got v2=%b n3=%0d want 1 2", ov2, cnt3);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({ov2, oc2, od2, cnt2, cnt3} !== '0) begin
      n_bad++;
      $display("FAIL arst_now: got v=%b c=%h d=%h n2=%0d n3=%0d want 0",
               ov2, oc2, od2, cnt2, cnt3);
    end
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    in_ctrl  = 9'h077;
    in_data  = 64'h77;
    for (int e = 1; e <= 3; e++) begin
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (e < 3 && ov3 !== 1'b0) begin
        n_bad++;
        $display("FAIL arst_lat%0d: got v=%b want 0", e, ov3);
      end else if (e == 3 && (ov3 !== 1'b1 || od3 !== 64'h77)) begin
        n_bad++;
        $display("FAIL arst_lat3: got v=%b d=%h want 1 77", ov3, od3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_depth1();
    test_stream();
    test_full();
    test_stall();
    test_flush(1'b0);
    test_flush(1'b1);
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data field through DEPTH slots, with a valid/ready handshake, bubble collapse, global stall, and flush.
- Slots emptied by reset, flush or start low always present an all-zero control field, so downstream stages never see write or read enables asserted for a bubble.

Parameters:
- DATA_W, 64: data payload width (ALU result, rs2 data, ...).
- CTRL_W, 9: control payload width (MemRead, MemtoReg, MemWrite, RegWrite, rd address, ...).
- DEPTH, 1: number of register slots, legal range 1..4.
- CNT_W, 3: width of count_o, must satisfy CNT_W >= clog2(DEPTH+1).

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: asynchronous, active-low reset.
- start_i, input, 1: CPU run enable; while low, the block behaves as flush_i=1.
- flush_i, input, 1: synchronous flush of all slots.
- stall_i, input, 1: global freeze, e.g. a memory stall.
- in_valid_i, input, 1: upstream item present.
- in_ready_o, output, 1: block accepts the item this cycle (combinational).
- in_ctrl_i, input, CTRL_W: upstream control field.
- in_data_i, input, DATA_W: upstream data field.
- out_valid_o, output, 1: output slot holds an item (registered).
- out_ready_i, input, 1: downstream accepts the item.
- out_ctrl_o, output, CTRL_W: control field of slot DEPTH-1; zero when out_valid_o=0.
- out_data_o, output, DATA_W: data field of slot DEPTH-1.
- count_o, output, CNT_W: number of valid slots (registered).

Behaviour:
- Slot numbering: slot 0 is the input side, slot DEPTH-1 is the output side. Each slot holds v[k], ctrl[k] and data[k].
- Reset (rst_i=0, asynchronous): every v, ctrl and data register is cleared to 0, so count_o=0, out_valid_o=0, out_ctrl_o=0 and out_data_o=0. After rst_i deasserts, registers update only on clock edges.
- Priority per edge: reset > flush (flush_i=1 or start_i=0) > stall > normal.
- Flush:
  - All v and ctrl are set to 0; data registers hold their values.
  - in_ready_o=0 during flush, so no input is accepted and no output transfer is counted.
- Stall (stall_i=1, no flush):
  - All registers hold.
  - in_ready_o=0.
  - out_valid_o and out_ctrl_o remain asserted/stable.
  - A downstream transfer does not occur even if out_ready_i=1.
- Normal operation, with moves evaluated combinationally from output to input:
  - leave[DEPTH-1] = v[DEPTH-1] & out_ready_i.
  - For k>0: move[k] = v[k-1] & (~v[k] | leave[k]), and leave[k-1] = move[k].
  - in_ready_o = ~v[0] | leave[0].
  - Slot 0 loads in_ctrl_i/in_data_i and sets v[0]=1 when in_valid_i & in_ready_o.
  - A slot k>0 with move[k] loads slot k-1's fields.
  - A slot that leaves and is not refilled clears v and ctrl; its data holds.
- Bubble collapse: an item advances into any empty downstream slot even while the output is blocked.
- Latency: in an empty pipe, an item accepted at edge t has out_valid_o=1 after edge t+DEPTH-1, i.e. it becomes visible DEPTH cycles after it is presented.
- Throughput: one item per cycle with out_ready_i held at 1.
- Full: when count_o==DEPTH and out_ready_i=0, in_ready_o=0. When full and out_ready_i=1, the block accepts an input in the same cycle (pass-through fill, no bubble).
- count_o updates each edge: +1 on accept, -1 on output transfer, unchanged when both or neither occur. It saturates at neither bound; overflow is impossible by construction.
- Simultaneous flush and in_valid_i: the input is dropped and upstream must not consider it transferred.
- Reset mid-operation: all in-flight items are lost; no partial state remains.

Test Plan:
- DEPTH=1: after reset, in_valid_i=1 with ctrl=9'h1A5, data=64'hDEAD → after one edge out_valid_o=1, out_ctrl_o=9'h1A5, out_data_o=64'hDEAD, count_o=1.
- DEPTH=3, out_ready_i=1, stream items 1..10 on consecutive cycles → out_data_o shows 1..10 on consecutive cycles, starting 3 cycles after item 1 is presented; in_ready_o stays 1 throughout.
- DEPTH=3, out_ready_i=0, push 4 items → count_o=3, in_ready_o=0, item 4 held upstream. Then set out_ready_i=1 for one cycle → item 1 leaves, item 4 accepted in the same edge, count_o stays 3.
- DEPTH=2, pipe full, assert stall_i=1 with out_ready_i=1 for 5 cycles → all outputs frozen, count_o=2, in_ready_o=0, no transfer.
- DEPTH=2, pipe full with ctrl=9'h1FF, assert flush_i with in_valid_i=1 → next edge count_o=0, out_valid_o=0, out_ctrl_o=0, input not accepted. Repeat with start_i=0 instead of flush_i → same result.
- Pipe half full; drive rst_i low asynchronously mid-cycle → outputs go to 0 immediately without waiting for a clock edge. After release, the first accepted item appears after DEPTH cycles.
